// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, mem-control field
// positions and the two-state access FSM.
package mips_mem_pkg;

    localparam logic [1:0] DSZ_B = 2'b00;
    localparam logic [1:0] DSZ_H = 2'b01;
    localparam logic [1:0] DSZ_W = 2'b10;
    localparam logic [1:0] DSZ_D = 2'b11;

    // Bit positions inside the {re,we,s_u,dsize} control word
    localparam int MEM_RE    = 4;
    localparam int MEM_WE    = 3;
    localparam int MEM_SU    = 2;
    localparam int MEM_DS_HI = 1;
    localparam int MEM_DS_LO = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store enables/data placement, load lane
// extraction with sign/zero extension, and alignment checking.
module mem_lane_align
    import mips_mem_pkg::*;
#(
    parameter int NB_REG = 32,
    parameter int NB_OFF = $clog2(NB_REG / 8)
) (
    input  logic [NB_OFF-1:0]   i_offset,
    input  logic [1:0]          i_dsize,
    input  logic                i_s_u,
    input  logic [NB_REG-1:0]   i_wdata,
    input  logic [NB_REG-1:0]   i_rdata,
    output logic [NB_REG/8-1:0] o_be,
    output logic [NB_REG-1:0]   o_wdata,
    output logic [NB_REG-1:0]   o_ext,
    output logic                o_misaligned
);
    localparam int NB_LANE = NB_REG / 8;

    logic [NB_LANE-1:0] w_be_base;
    logic [NB_REG-1:0]  w_rep;
    logic [NB_REG-1:0]  w_shifted;
    logic [NB_REG-1:0]  w_keep;
    logic               w_sign;

    always_comb begin
        w_be_base    = '0;
        w_rep        = i_wdata;
        o_misaligned = 1'b0;
        case (i_dsize)
            DSZ_B: begin
                w_be_base = NB_LANE'(1);
                w_rep     = {NB_LANE{i_wdata[7:0]}};
            end
            DSZ_H: begin
                w_be_base    = NB_LANE'(3);
                w_rep        = {(NB_LANE / 2){i_wdata[15:0]}};
                o_misaligned = i_offset[0];
            end
            DSZ_W: begin
                w_be_base    = NB_LANE'(15);
                w_rep        = {(NB_REG / 32){i_wdata[31:0]}};
                o_misaligned = |i_offset[1:0];
            end
            default: begin
                // Doubleword only exists on the 64-bit datapath
                w_be_base    = '1;
                w_rep        = i_wdata;
                o_misaligned = (NB_REG != 64) || (|i_offset);
            end
        endcase
    end

    assign o_be = w_be_base << i_offset;

    // Unselected lanes are driven to zero so the bus only sees real data
    for (genvar gi = 0; gi < NB_LANE; gi++) begin : g_lane
        assign o_wdata[gi*8 +: 8] = o_be[gi] ? w_rep[gi*8 +: 8] : 8'h00;
    end

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        w_keep = '1;
        w_sign = 1'b0;
        case (i_dsize)
            DSZ_B: begin
                w_keep = NB_REG'(8'hFF);
                w_sign = w_shifted[7];
            end
            DSZ_H: begin
                w_keep = NB_REG'(16'hFFFF);
                w_sign = w_shifted[15];
            end
            DSZ_W: begin
                w_keep = NB_REG'(32'hFFFF_FFFF);
                w_sign = w_shifted[31];
            end
            default: begin
                w_keep = '1;
                w_sign = 1'b0;
            end
        endcase
        o_ext = (w_shifted & w_keep) | ((~i_s_u & w_sign) ? ~w_keep : '0);
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage driving a variable-latency req/ack data-memory port,
// with upstream stall, misalignment and bus-timeout reporting.
module mem_stage_lsu
    import mips_mem_pkg::*;
#(
    parameter int NB_REG  = 32,
    parameter int NB_ADDR = 32,
    parameter int NB_MEM  = 5,
    parameter int NB_WB   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic [NB_ADDR-1:0]   i_alu_o,
    input  logic [NB_REG-1:0]    i_b_o,
    input  logic [NB_MEM-1:0]    i_mem,
    input  logic [NB_WB-1:0]     i_wb,
    input  logic [NB_REG-1:0]    i_pc,
    output logic                 o_stall,
    output logic                 o_valid,
    output logic [NB_REG-1:0]    o_reg_wb,
    output logic [NB_REG-1:0]    o_ext_mem_o,
    output logic [NB_WB-1:0]     o_wb,
    output logic [NB_REG-1:0]    o_pc,
    output logic                 o_misaligned,
    output logic                 o_bus_err,
    output logic                 o_dmem_req,
    output logic [NB_ADDR-1:0]   o_dmem_addr,
    output logic [NB_REG/8-1:0]  o_dmem_we,
    output logic [NB_REG-1:0]    o_dmem_wdata,
    input  logic                 i_dmem_ack,
    input  logic [NB_REG-1:0]    i_dmem_rdata
);
    localparam int NB_LANE = NB_REG / 8;
    localparam int NB_OFF  = $clog2(NB_LANE);
    localparam int NB_CNT  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t r_state;
    state_t w_state_next;

    logic               w_re, w_we, w_s_u, w_memop;
    logic [1:0]         w_dsize;
    logic               w_busy, w_issue, w_timeout, w_done;
    logic [NB_OFF-1:0]  w_off_sel;
    logic [1:0]         w_dsize_sel;
    logic               w_su_sel;
    logic [NB_LANE-1:0] w_be;
    logic [NB_REG-1:0]  w_wdata;
    logic [NB_REG-1:0]  w_ext;
    logic               w_misaligned;

    logic [NB_ADDR-1:0] r_addr;
    logic [NB_REG-1:0]  r_pc_lat;
    logic [NB_WB-1:0]   r_wb_lat;
    logic [NB_LANE-1:0] r_be;
    logic [NB_REG-1:0]  r_wdata;
    logic [1:0]         r_dsize;
    logic               r_s_u;
    logic               r_is_load;
    logic [NB_CNT-1:0]  r_cnt;

    logic               r_valid;
    logic [NB_REG-1:0]  r_reg_wb;
    logic [NB_REG-1:0]  r_ext;
    logic [NB_WB-1:0]   r_wb;
    logic [NB_REG-1:0]  r_pc;
    logic               r_misaligned;
    logic               r_bus_err;

    assign w_re    = i_mem[MEM_RE];
    assign w_we    = i_mem[MEM_WE];
    assign w_s_u   = i_mem[MEM_SU];
    assign w_dsize = i_mem[MEM_DS_HI:MEM_DS_LO];
    assign w_memop = w_re | w_we;

    assign w_busy    = (r_state == ST_BUSY);
    assign w_issue   = (r_state == ST_IDLE) & i_valid & w_memop & ~w_misaligned;
    assign w_timeout = w_busy & ~i_dmem_ack & (TIMEOUT != 0) & (r_cnt == CNT_LAST);
    assign w_done    = w_busy & (i_dmem_ack | w_timeout);
    assign o_stall   = w_issue | (w_busy & ~w_done);

    // While BUSY the aligner works on the latched access for load extraction
    assign w_off_sel   = w_busy ? r_addr[NB_OFF-1:0] : i_alu_o[NB_OFF-1:0];
    assign w_dsize_sel = w_busy ? r_dsize : w_dsize;
    assign w_su_sel    = w_busy ? r_s_u : w_s_u;

    mem_lane_align #(
        .NB_REG (NB_REG),
        .NB_OFF (NB_OFF)
    ) u_align (
        .i_offset     (w_off_sel),
        .i_dsize      (w_dsize_sel),
        .i_s_u        (w_su_sel),
        .i_wdata      (i_b_o),
        .i_rdata      (i_dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_ext        (w_ext),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_issue) w_state_next = ST_BUSY;
            ST_BUSY: if (w_done)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_addr    <= '0;
            r_pc_lat  <= '0;
            r_wb_lat  <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_dsize   <= '0;
            r_s_u     <= 1'b0;
            r_is_load <= 1'b0;
            r_cnt     <= '0;
        end else if (w_issue) begin
            r_addr    <= i_alu_o;
            r_pc_lat  <= i_pc;
            r_wb_lat  <= i_wb;
            r_be      <= w_we ? w_be : '0;
            r_wdata   <= w_we ? w_wdata : '0;
            r_dsize   <= w_dsize;
            r_s_u     <= w_s_u;
            r_is_load <= w_re & ~w_we;
            r_cnt     <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + NB_CNT'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid      <= 1'b0;
            r_reg_wb     <= '0;
            r_ext        <= '0;
            r_wb         <= '0;
            r_pc         <= '0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
        end else if (w_busy) begin
            r_valid <= w_done;
            if (w_done) begin
                r_reg_wb     <= NB_REG'(r_addr);
                r_pc         <= r_pc_lat;
                r_ext        <= (i_dmem_ack && r_is_load) ? w_ext : '0;
                r_wb         <= i_dmem_ack ? r_wb_lat : '0;
                r_misaligned <= 1'b0;
                r_bus_err    <= ~i_dmem_ack;
            end
        end else if (i_valid && !w_issue) begin
            // ALU pass-through or misaligned access: single-cycle completion
            r_valid      <= 1'b1;
            r_reg_wb     <= NB_REG'(i_alu_o);
            r_pc         <= i_pc;
            r_ext        <= '0;
            r_wb         <= w_memop ? '0 : i_wb;
            r_misaligned <= w_memop;
            r_bus_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid      = r_valid;
    assign o_reg_wb     = r_reg_wb;
    assign o_ext_mem_o  = r_ext;
    assign o_wb         = r_wb;
    assign o_pc         = r_pc;
    assign o_misaligned = r_misaligned;
    assign o_bus_err    = r_bus_err;
    assign o_dmem_req   = w_busy;
    assign o_dmem_addr  = {r_addr[NB_ADDR-1:NB_OFF], NB_OFF'(0)};
    assign o_dmem_we    = r_be;
    assign o_dmem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench: a 32-bit and a 64-bit instance, both with a short bus
// timeout, exercised with stores, loads, misaligned ops, timeouts and reset.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] alu   = '0;
    logic [63:0] bdat  = '0;
    logic [63:0] pc    = '0;
    logic [63:0] rdata = '0;
    logic [4:0]  mem   = '0;
    logic [7:0]  wb    = '0;
    logic        va = 1'b0, vb = 1'b0, acka = 1'b0, ackb = 1'b0;

    logic        a_stall, a_valid, a_mis, a_bus, a_req;
    logic [31:0] a_reg_wb, a_ext, a_pc, a_addr, a_wdata;
    logic [7:0]  a_wb;
    logic [3:0]  a_we;

    logic        b_stall, b_valid, b_mis, b_bus, b_req;
    logic [63:0] b_reg_wb, b_ext, b_pc, b_wdata;
    logic [31:0] b_addr;
    logic [7:0]  b_wb, b_we;

    mem_stage_lsu #(.NB_REG(32), .NB_ADDR(32), .NB_MEM(5), .NB_WB(8), .TIMEOUT(4)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_valid(va), .i_alu_o(alu), .i_b_o(bdat[31:0]),
        .i_mem(mem), .i_wb(wb), .i_pc(pc[31:0]), .o_stall(a_stall), .o_valid(a_valid),
        .o_reg_wb(a_reg_wb), .o_ext_mem_o(a_ext), .o_wb(a_wb), .o_pc(a_pc),
        .o_misaligned(a_mis), .o_bus_err(a_bus), .o_dmem_req(a_req), .o_dmem_addr(a_addr),
        .o_dmem_we(a_we), .o_dmem_wdata(a_wdata), .i_dmem_ack(acka), .i_dmem_rdata(rdata[31:0])
    );

    mem_stage_lsu #(.NB_REG(64), .NB_ADDR(32), .NB_MEM(5), .NB_WB(8), .TIMEOUT(4)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_valid(vb), .i_alu_o(alu), .i_b_o(bdat),
        .i_mem(mem), .i_wb(wb), .i_pc(pc), .o_stall(b_stall), .o_valid(b_valid),
        .o_reg_wb(b_reg_wb), .o_ext_mem_o(b_ext), .o_wb(b_wb), .o_pc(b_pc),
        .o_misaligned(b_mis), .o_bus_err(b_bus), .o_dmem_req(b_req), .o_dmem_addr(b_addr),
        .o_dmem_we(b_we), .o_dmem_wdata(b_wdata), .i_dmem_ack(ackb), .i_dmem_rdata(rdata)
    );

    typedef struct {
        string       tag;
        logic [63:0] reg_wb;
        logic [63:0] ext;
        logic [63:0] pc;
        logic [7:0]  wb;
        logic        mis;
        logic        bus;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst && a_valid) begin
            if (q_a.size() == 0) check_val("a_unexpected_valid", 1, 0);
            else begin
                e = q_a.pop_front();
                check_val({e.tag, "_regwb"}, {32'h0, a_reg_wb}, e.reg_wb);
                check_val({e.tag, "_ext"},   {32'h0, a_ext},    e.ext);
                check_val({e.tag, "_pc"},    {32'h0, a_pc},     e.pc);
                check_val({e.tag, "_wb"},    a_wb,              e.wb);
                check_val({e.tag, "_flags"}, {a_mis, a_bus},    {e.mis, e.bus});
                $display("txn A %s: addr=%h ext=%h wb=%h mis=%0d bus=%0d",
                         e.tag, a_reg_wb, a_ext, a_wb, a_mis, a_bus);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst && b_valid) begin
            if (q_b.size() == 0) check_val("b_unexpected_valid", 1, 0);
            else begin
                e = q_b.pop_front();
                check_val({e.tag, "_regwb"}, b_reg_wb,       e.reg_wb);
                check_val({e.tag, "_ext"},   b_ext,          e.ext);
                check_val({e.tag, "_pc"},    b_pc,           e.pc);
                check_val({e.tag, "_wb"},    b_wb,           e.wb);
                check_val({e.tag, "_flags"}, {b_mis, b_bus}, {e.mis, e.bus});
                $display("txn B %s: addr=%h ext=%h wb=%h mis=%0d bus=%0d",
                         e.tag, b_reg_wb, b_ext, b_wb, b_mis, b_bus);
            end
        end
    end

    // Drives one EX/MEM entry, acks after ack_delay BUSY cycles (-1: never),
    // and returns in the cycle the stage accepts it (o_stall low).
    task automatic op(input bit sel, input string tag, input logic [31:0] addr,
                      input logic [63:0] b, input logic [4:0] m, input logic [63:0] rd,
                      input int ack_delay, input logic [63:0] exp_ext,
                      input bit exp_mis, input bit exp_bus,
                      output int n_stall, output int n_req, output logic [7:0] we_seen,
                      output logic [63:0] wdata_seen, output logic [31:0] addr_seen);
        exp_t e;
        bit   done;
        int   nbusy;
        @(negedge clk);
        alu = addr; bdat = b; mem = m; rdata = rd;
        wb  = 8'h80 | addr[6:0];
        pc  = {32'h0, 32'h0040_0000 + addr};
        e.tag = tag; e.reg_wb = {32'h0, addr}; e.ext = exp_ext; e.pc = pc;
        e.wb = (exp_mis || exp_bus) ? 8'h00 : wb; e.mis = exp_mis; e.bus = exp_bus;
        if (sel) q_b.push_back(e); else q_a.push_back(e);
        va = ~sel; vb = sel; acka = 1'b0; ackb = 1'b0;
        n_stall = 0; n_req = 0; nbusy = 0; done = 1'b0;
        we_seen = '0; wdata_seen = '0; addr_seen = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                acka = 1'b0; ackb = 1'b0;
            end
            #1;
            if (sel ? b_req : a_req) begin
                n_req++;
                if (n_req == 1) begin
                    we_seen    = sel ? b_we : {4'h0, a_we};
                    wdata_seen = sel ? b_wdata : {32'h0, a_wdata};
                    addr_seen  = sel ? b_addr : a_addr;
                end
                if (nbusy == ack_delay) begin
                    if (sel) ackb = 1'b1; else acka = 1'b1;
                end
                nbusy++;
            end
            #1;
            if (sel ? b_stall : a_stall) n_stall++;
            else done = 1'b1;
        end
        if (!done) check_val({tag, "_hang"}, 1, 0);
    endtask

    task automatic idle();
        @(negedge clk);
        va = 1'b0; vb = 1'b0; acka = 1'b0; ackb = 1'b0; mem = '0;
    endtask

    int          ns, nr;
    logic [7:0]  wes;
    logic [63:0] wds;
    logic [31:0] ads;

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_a_ctl",  {a_valid, a_mis, a_bus, a_req, a_stall}, 0);
        check_val("rst_a_data", {a_reg_wb, a_ext}, 0);
        check_val("rst_a_misc", {a_pc, a_wb, a_we}, 0);
        check_val("rst_a_bus",  {a_addr, a_wdata}, 0);
        check_val("rst_b_ctl",  {b_valid, b_mis, b_bus, b_req, b_stall, b_we, b_wb}, 0);
        check_val("rst_b_data", b_reg_wb | b_ext | b_pc | b_wdata | {32'h0, b_addr}, 0);
        rst = 1'b0;

        // SB 0xAB at offset 3, ack after three BUSY cycles
        op(0, "sb3", 32'h0000_1003, 64'hAB, 5'b01000, 64'h0, 3, 64'h0, 0, 0, ns, nr, wes, wds, ads);
        check_val("sb3_stall", ns, 4);
        check_val("sb3_req", nr, 4);
        check_val("sb3_we", wes, 8'b0000_1000);
        check_val("sb3_wdata", wds & 64'hFF00_0000, 64'hAB00_0000);
        check_val("sb3_addr", ads, 32'h0000_1000);

        op(0, "lh_s", 32'h0000_1002, 64'h0, 5'b10001, 64'h8001_1234, 1, 64'hFFFF_8001, 0, 0, ns, nr, wes, wds, ads);
        check_val("lh_s_we", wes, 8'h00);
        op(0, "lh_u", 32'h0000_1002, 64'h0, 5'b10101, 64'h8001_1234, 0, 64'h0000_8001, 0, 0, ns, nr, wes, wds, ads);
        check_val("lh_u_stall", ns, 1);

        op(0, "lw_mis", 32'h0000_1002, 64'h0, 5'b10010, 64'hFFFF_FFFF, 0, 64'h0, 1, 0, ns, nr, wes, wds, ads);
        check_val("lw_mis_req", nr, 0);
        check_val("lw_mis_stall", ns, 0);

        op(0, "sh2", 32'h0000_1002, 64'hBEEF, 5'b01001, 64'h0, 0, 64'h0, 0, 0, ns, nr, wes, wds, ads);
        check_val("sh2_we", wes, 8'b0000_1100);
        check_val("sh2_wdata", wds, 64'hBEEF_0000);
        op(0, "lb1", 32'h0000_1001, 64'h0, 5'b10000, 64'h0000_F000, 0, 64'hFFFF_FFF0, 0, 0, ns, nr, wes, wds, ads);
        op(0, "rewe", 32'h0000_1004, 64'hCAFE_F00D, 5'b11010, 64'hFFFF_FFFF, 0, 64'h0, 0, 0, ns, nr, wes, wds, ads);
        check_val("rewe_we", wes, 8'h0F);
        op(0, "sd32", 32'h0000_3000, 64'h0, 5'b01011, 64'h0, 0, 64'h0, 1, 0, ns, nr, wes, wds, ads);
        check_val("sd32_req", nr, 0);

        // Timeout after four request cycles, then a stray ack must do nothing
        op(0, "tmo", 32'h0000_1010, 64'h0, 5'b10010, 64'h1234_5678, -1, 64'h0, 0, 1, ns, nr, wes, wds, ads);
        check_val("tmo_req", nr, 4);
        idle();
        @(negedge clk);
        acka = 1'b1;
        #2;
        check_val("late_ack_req", a_req, 0);
        check_val("late_ack_stall", a_stall, 0);
        @(negedge clk);
        acka = 1'b0;
        check_val("late_ack_valid", a_valid, 0);

        // 64-bit datapath
        op(1, "sd8", 32'h0000_2008, 64'h0123_4567_89AB_CDEF, 5'b01011, 64'h0, 1, 64'h0, 0, 0, ns, nr, wes, wds, ads);
        check_val("sd8_we", wes, 8'hFF);
        check_val("sd8_wdata", wds, 64'h0123_4567_89AB_CDEF);
        check_val("sd8_addr", ads, 32'h0000_2008);
        op(1, "lw4_s", 32'h0000_2004, 64'h0, 5'b10010, 64'h8000_0000_1234_5678, 0, 64'hFFFF_FFFF_8000_0000, 0, 0, ns, nr, wes, wds, ads);
        check_val("lw4_s_addr", ads, 32'h0000_2000);
        op(1, "lw4_u", 32'h0000_2004, 64'h0, 5'b10110, 64'h8000_0000_1234_5678, 0, 64'h0000_0000_8000_0000, 0, 0, ns, nr, wes, wds, ads);
        op(1, "lb5", 32'h0000_2005, 64'h0, 5'b10000, 64'h0000_9C00_0000_0000, 2, 64'hFFFF_FFFF_FFFF_FF9C, 0, 0, ns, nr, wes, wds, ads);
        op(1, "sw4", 32'h0000_2004, 64'h0000_0000_DEAD_BEEF, 5'b01010, 64'h0, 0, 64'h0, 0, 0, ns, nr, wes, wds, ads);
        check_val("sw4_we", wes, 8'hF0);
        check_val("sw4_wdata", wds, 64'hDEAD_BEEF_0000_0000);
        op(1, "ld_mis", 32'h0000_2004, 64'h0, 5'b10011, 64'h0, 0, 64'h0, 1, 0, ns, nr, wes, wds, ads);
        idle();

        // Reset while an access is pending
        @(negedge clk);
        alu = 32'h0000_1008; mem = 5'b10010; va = 1'b1; vb = 1'b0; acka = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst6_req_before", a_req, 1);
        rst = 1'b1; va = 1'b0;
        @(negedge clk);
        check_val("rst6_req", a_req, 0);
        check_val("rst6_ctl", {a_valid, a_mis, a_bus, a_stall}, 0);
        check_val("rst6_data", {a_reg_wb, a_pc}, 0);
        rst = 1'b0;

        // Back-to-back ALU ops flow one per cycle
        op(0, "alu0", 32'h0000_0100, 64'h0, 5'b00000, 64'h0, 0, 64'h0, 0, 0, ns, nr, wes, wds, ads);
        check_val("alu0_stall", ns, 0);
        op(0, "alu1", 32'h0000_0204, 64'h0, 5'b00011, 64'h0, 0, 64'h0, 0, 0, ns, nr, wes, wds, ads);
        check_val("alu1_stall", ns, 0);
        op(0, "alu2", 32'h0000_0308, 64'h0, 5'b00100, 64'h0, 0, 64'h0, 0, 0, ns, nr, wes, wds, ads);
        check_val("alu2_req", nr, 0);
        idle();
        repeat (2) @(negedge clk);
        check_val("hold_regwb", a_reg_wb, 32'h0000_0308);
        check_val("hold_valid", a_valid, 0);

        repeat (3) @(negedge clk);
        check_val("qa_empty", q_a.size(), 0);
        check_val("qb_empty", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
